// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer blocks (write and read side).
// Gray/binary conversions take a 32-bit argument; callers zero-extend narrower pointers.
package fifo_pkg;

    localparam int FIFO_ADDRSIZE = 4;
    localparam int DEPTH         = 2 ** FIFO_ADDRSIZE;

    function automatic int fifo_depth(input int addrsize);
        return 2 ** addrsize;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return (b >> 1) ^ b;
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it; zero upper bits are harmless.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int i = 31; i >= 0; i--) begin
            b[i] = (i == 31) ? g[i] : (b[i+1] ^ g[i]);
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full.sv
// Write-side pointer, full/almost-full flags, occupancy estimate and sticky overflow
// for the dual-clock FIFO; everything runs in the wclk domain.
module wptr_full
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic                woverflow_clr,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wcount,
    output logic                woverflow
);

    localparam logic [ADDRSIZE:0] AF_LVL = (ADDRSIZE+1)'(AFULL_THRESH);

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbinnext;
    logic [ADDRSIZE:0] wgraynext;
    logic [ADDRSIZE:0] rbin_s;
    logic [ADDRSIZE:0] wdiff;
    logic [ADDRSIZE:0] rptr_full_pat;
    logic              wpush;
    logic              wdrop;

    always_comb begin
        wpush         = winc & ~wfull;
        wdrop         = winc & wfull;
        wbinnext      = wbin + {{ADDRSIZE{1'b0}}, wpush};
        wgraynext     = (ADDRSIZE+1)'(bin2gray(32'(wbinnext)));
        rbin_s        = (ADDRSIZE+1)'(gray2bin(32'(wq2_rptr)));
        wdiff         = wbinnext - rbin_s;
        // Full when the write pointer has lapped the read pointer: top two Gray bits inverted.
        rptr_full_pat = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wcount       <= '0;
            woverflow    <= 1'b0;
        end else begin
            wbin         <= wbinnext;
            wptr         <= wgraynext;
            wfull        <= (wgraynext == rptr_full_pat);
            walmost_full <= (wdiff >= AF_LVL);
            wcount       <= wdiff;
            // A dropped write in the same cycle as a clear keeps the flag set.
            woverflow    <= woverflow_clr ? wdrop : (woverflow | wdrop);
        end
    end

    assign waddr = wbin[ADDRSIZE-1:0];

endmodule

// File: tb/tb_wptr_full.sv
// Randomised and directed bench for wptr_full against an occupancy-counting model.
module tb_wptr_full;

    localparam int AW  = 4;
    localparam int DEP = 16;
    localparam int AFT = 12;

    logic          wclk;
    logic          wrst;
    logic          winc;
    logic          woverflow_clr;
    logic [AW:0]   wq2_rptr;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr;
    logic          wfull;
    logic          walmost_full;
    logic [AW:0]   wcount;
    logic          woverflow;

    wptr_full #(.ADDRSIZE(AW), .AFULL_THRESH(AFT)) dut (
        .wclk(wclk), .wrst(wrst), .winc(winc), .woverflow_clr(woverflow_clr),
        .wq2_rptr(wq2_rptr), .waddr(waddr), .wptr(wptr), .wfull(wfull),
        .walmost_full(walmost_full), .wcount(wcount), .woverflow(woverflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int checks   = 0;
    int failures = 0;
    bit check_en = 0;

    // Model: total writes accepted and total reads seen, as plain integers.
    int w_total = 0;
    int rd_total = 0;
    int e_waddr, e_wptr, e_wcount;
    bit e_full, e_af, e_ovf;

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge wclk) begin
        if (check_en) begin
            chk("waddr", int'(waddr), e_waddr);
            chk("wptr", int'(wptr), e_wptr);
            chk("wcount", int'(wcount), e_wcount);
            chk("wfull", int'(wfull), int'(e_full));
            chk("walmost_full", int'(walmost_full), int'(e_af));
            chk("woverflow", int'(woverflow), int'(e_ovf));
        end
    end

    // Drive one cycle's inputs (called at a negedge), advance the model at the posedge.
    task automatic step(input bit inc, input bit adv, input bit clr, input bit rst);
        int occ;
        bit drop;
        wrst          = rst;
        winc          = inc;
        woverflow_clr = clr;
        if (rst) rd_total = 0;
        else if (adv) rd_total++;
        wq2_rptr = (AW+1)'(gray(rd_total % (2*DEP)));
        @(posedge wclk);
        if (rst) begin
            w_total = 0;
            e_waddr = 0; e_wptr = 0; e_wcount = 0;
            e_full = 0; e_af = 0; e_ovf = 0;
        end else begin
            drop = inc && e_full;
            if (inc && !e_full) w_total++;
            occ      = w_total - rd_total;
            e_wcount = occ;
            e_full   = (occ == DEP);
            e_af     = (occ >= AFT);
            e_waddr  = w_total % DEP;
            e_wptr   = gray(w_total % (2*DEP));
            e_ovf    = clr ? drop : (e_ovf | drop);
        end
        @(negedge wclk);
    endtask

    initial begin
        logic [AW:0] prev;
        wrst = 1; winc = 0; woverflow_clr = 0; wq2_rptr = '0;
        @(negedge wclk);

        // Reset with winc held high.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
        check_en = 1;
        chk("rst_wptr", int'(wptr), 0);
        chk("rst_wcount", int'(wcount), 0);
        step(1, 0, 0, 0);
        chk("first_waddr", int'(waddr), 1);
        chk("first_wptr", int'(wptr), 5'b00001);
        chk("first_wcount", int'(wcount), 1);

        // Fill to full with the read pointer parked at 0.
        for (int i = 2; i <= 16; i++) begin
            step(1, 0, 0, 0);
            if (i == 11) chk("af_before", int'(walmost_full), 0);
            if (i == 12) chk("af_at12", int'(walmost_full), 1);
            if (i == 15) chk("full_before", int'(wfull), 0);
        end
        chk("full_at16", int'(wfull), 1);
        chk("full_wptr", int'(wptr), 5'b11000);
        chk("full_wcount", int'(wcount), 16);
        step(1, 0, 0, 0);
        chk("ovf_waddr", int'(waddr), 0);
        chk("ovf_set", int'(woverflow), 1);

        // Read side frees one slot; the write in that same cycle is refused.
        step(1, 1, 0, 0);
        chk("drain_full", int'(wfull), 0);
        chk("drain_wcount", int'(wcount), 15);
        chk("drain_af", int'(walmost_full), 1);
        chk("drain_waddr", int'(waddr), 0);
        step(1, 0, 0, 0);
        chk("refill_full", int'(wfull), 1);
        chk("refill_waddr", int'(waddr), 1);

        // Clear collides with a dropped write, then clear alone.
        step(1, 0, 1, 0);
        chk("clr_set_wins", int'(woverflow), 1);
        step(0, 0, 1, 0);
        chk("clr_alone", int'(woverflow), 0);

        // Lockstep read/write across the pointer wrap.
        step(0, 1, 0, 0);
        prev = wptr;
        for (int i = 0; i < 40; i++) begin
            step(1, 1, 0, 0);
            chk("wrap_onebit", $countones(wptr ^ prev), 1);
            chk("wrap_wcount", int'(wcount), 15);
            chk("wrap_full", int'(wfull), 0);
            prev = wptr;
        end

        // Reset mid-operation.
        step(0, 0, 0, 1);
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0);
        chk("mid_wcount", int'(wcount), 9);
        step(1, 0, 0, 1);
        chk("mid_rst_waddr", int'(waddr), 0);
        chk("mid_rst_wcount", int'(wcount), 0);
        step(1, 0, 0, 0);
        chk("mid_rst_first", int'(waddr), 1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit inc, adv, clr, rst;
            inc = ($urandom_range(99) < 60);
            adv = ($urandom_range(99) < 45) && (rd_total < w_total);
            clr = ($urandom_range(99) < 5);
            rst = ($urandom_range(999) < 3);
            step(inc, adv, clr, rst);
        end

        check_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
